// File: rtl/ascii_pkg.sv
// Shared definitions for the keypad/terminal character path (decoder and transmitter).
//  - code_t: 4-bit character code (0..9 digits, then SPACE..NONE control codes)
//  - code_to_ascii(): code -> ASCII byte
//  - pow10(): elaboration helper for digit-count checks
//  - state_e: transmitter FSM encoding
package ascii_pkg;

  typedef logic [3:0] code_t;

  localparam code_t SPACE    = 4'd10;
  localparam code_t ENTER    = 4'd11;
  localparam code_t FORWARD  = 4'd12;
  localparam code_t BACKWARD = 4'd13;
  localparam code_t INVALID  = 4'd14;
  localparam code_t NONE     = 4'd15;

  typedef enum logic [2:0] {
    StIdle,
    StConv,
    StSign,
    StDigit,
    StTerm
  } state_e;

  // NONE has no printable form and maps to 8'h00.
  function automatic logic [7:0] code_to_ascii(code_t code);
    logic [7:0] ch;
    ch = 8'h00;
    if (code <= 4'd9) begin
      ch = {4'h3, code};
    end else begin
      case (code)
        SPACE:    ch = 8'h20;
        ENTER:    ch = 8'h0D;
        FORWARD:  ch = 8'h2B;
        BACKWARD: ch = 8'h2D;
        INVALID:  ch = 8'h3F;
        default:  ch = 8'h00;
      endcase
    end
    return ch;
  endfunction

  function automatic longint unsigned pow10(int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one shift-and-add-3 step per cycle.
//  clk    in   1          clock, rising edge
//  rst    in   1          synchronous active-high reset
//  start  in   1          load value and begin a WIDTH-step conversion
//  value  in   WIDTH      unsigned binary input, sampled on start
//  done   out  1          high during the final step; bcd is complete from the next cycle
//  bcd    out  DIGITS*4   packed BCD result, digit 0 in bits [3:0]
module bin_to_bcd
  import ascii_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    value,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam longint unsigned Pow10Digits = pow10(DIGITS);

  if (Pow10Digits <= (64'd1 << WIDTH)) begin : g_digits_check
    $error("bin_to_bcd: DIGITS too small to hold 2**WIDTH - 1");
  end

  logic [WIDTH-1:0]          shift_q;
  logic [4*DIGITS-1:0]       bcd_q;
  logic [CntW-1:0]           cnt_q;
  logic [4*DIGITS-1:0]       adj;
  logic [4*DIGITS+WIDTH-1:0] step;

  // Add 3 to every digit >= 5 so the following shift carries correctly into the next digit.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    step = {adj, shift_q} << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else if (start) begin
      shift_q <= value;
      bcd_q   <= '0;
      cnt_q   <= CntW'(WIDTH);
    end else if (cnt_q != '0) begin
      shift_q <= step[WIDTH-1:0];
      bcd_q   <= step[4*DIGITS+WIDTH-1:WIDTH];
      cnt_q   <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == CntW'(1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/dec_to_ascii_tx.sv
// Prints a binary value as decimal ASCII followed by an optional terminator character over a
// valid/ready byte stream (feeds the UART transmitter).
//  i_Clk       in   1      clock, rising edge
//  i_Rst       in   1      synchronous active-high reset
//  i_Start     in   1      accept i_Value while o_Ready=1
//  i_Value     in   WIDTH  value to print
//  o_Ready     out  1      idle
//  o_Tx_Valid  out  1      o_Tx_Byte holds a character
//  o_Tx_Byte   out  8      ASCII character
//  i_Tx_Ready  in   1      sink accepts the byte
// Build option: define DEC_TO_ASCII_SIGNED_EN to treat i_Value as two's complement and emit a
// leading '-' for negative values.
module dec_to_ascii_tx
  import ascii_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DIGITS    = 5,
  parameter int unsigned TERM_CODE = 11
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic [WIDTH-1:0] i_Value,
  output logic             o_Ready,
  output logic             o_Tx_Valid,
  output logic [7:0]       o_Tx_Byte,
  input  logic             i_Tx_Ready
);

  localparam int unsigned IdxW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0]  TermByte = code_to_ascii(code_t'(TERM_CODE));
  localparam bit          SkipTerm = (code_t'(TERM_CODE) == NONE);

  state_e              state_q, state_d;
  logic                valid_q;
  logic [7:0]          byte_q;
  logic [IdxW-1:0]     idx_q;
  logic                first_q;
  logic                conv_start, conv_done;
  logic [WIDTH-1:0]    conv_value;
  logic [4*DIGITS-1:0] bcd;
  logic [IdxW-1:0]     msd, cur_idx;
  code_t               digit;
  logic                tx_xfer, load;
  logic [7:0]          load_byte;

`ifdef DEC_TO_ASCII_SIGNED_EN
  logic neg_q;
  // -2**(WIDTH-1) negates to itself, which read as unsigned is the correct magnitude.
  assign conv_value = i_Value[WIDTH-1] ? (~i_Value + 1'b1) : i_Value;
`else
  assign conv_value = i_Value;
`endif

  bin_to_bcd #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin_to_bcd (
    .clk   (i_Clk),
    .rst   (i_Rst),
    .start (conv_start),
    .value (conv_value),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Most significant non-zero digit; all-zero falls back to digit 0 so 0 prints as '0'.
  always_comb begin
    msd = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        msd = IdxW'(i);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (i_Start) state_d = StConv;
      StConv: begin
        if (conv_done) begin
`ifdef DEC_TO_ASCII_SIGNED_EN
          state_d = neg_q ? StSign : StDigit;
`else
          state_d = StDigit;
`endif
        end
      end
      StSign: if (tx_xfer) state_d = StDigit;
      StDigit: begin
        if (tx_xfer && (idx_q == '0)) state_d = SkipTerm ? StIdle : StTerm;
      end
      StTerm: if (tx_xfer) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_Ready    = (state_q == StIdle);
    conv_start = (state_q == StIdle) && i_Start;
    tx_xfer    = valid_q && i_Tx_Ready;
    load       = ((state_q == StSign) || (state_q == StDigit) || (state_q == StTerm)) && !valid_q;
    cur_idx    = first_q ? msd : idx_q;
    digit      = bcd[4*int'(cur_idx) +: 4];
    load_byte  = 8'h00;
    unique case (state_q)
      StSign:  load_byte = code_to_ascii(BACKWARD);
      StDigit: load_byte = code_to_ascii(digit);
      StTerm:  load_byte = TermByte;
      default: load_byte = 8'h00;
    endcase
  end

  // idx_q holds the index of the digit currently presented, so the transfer of digit 0 ends
  // the digit run. first_q selects the leading-zero encoder for the first digit load.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      valid_q <= 1'b0;
      byte_q  <= 8'h00;
      idx_q   <= '0;
      first_q <= 1'b0;
    end else begin
      if (tx_xfer) begin
        valid_q <= 1'b0;
        if ((state_q == StDigit) && (idx_q != '0)) idx_q <= idx_q - 1'b1;
      end else if (load) begin
        valid_q <= 1'b1;
        byte_q  <= load_byte;
        if (state_q == StDigit) begin
          idx_q   <= cur_idx;
          first_q <= 1'b0;
        end
      end
      if (state_q == StConv) first_q <= 1'b1;
    end
  end

`ifdef DEC_TO_ASCII_SIGNED_EN
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      neg_q <= 1'b0;
    end else if (conv_start) begin
      neg_q <= i_Value[WIDTH-1];
    end
  end
`endif

  assign o_Tx_Valid = valid_q;
  assign o_Tx_Byte  = byte_q;

endmodule

// File: tb/tb_dec_to_ascii_tx.sv
module tb_dec_to_ascii_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] value = 16'd0;
  logic        tx_ready = 1'b1;

  logic       rdy [3];
  logic       vld [3];
  logic [7:0] byt [3];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];

  always #5 clk = ~clk;

  // Instance 0: TERM_CODE=11 (ENTER), 1: 15 (no terminator), 2: 10 (SPACE); shared stimulus.
  dec_to_ascii_tx #(.WIDTH(16), .DIGITS(5), .TERM_CODE(11)) u_dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Value(value),
    .o_Ready(rdy[0]), .o_Tx_Valid(vld[0]), .o_Tx_Byte(byt[0]), .i_Tx_Ready(tx_ready)
  );
  dec_to_ascii_tx #(.WIDTH(16), .DIGITS(5), .TERM_CODE(15)) u_dut_t15 (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Value(value),
    .o_Ready(rdy[1]), .o_Tx_Valid(vld[1]), .o_Tx_Byte(byt[1]), .i_Tx_Ready(tx_ready)
  );
  dec_to_ascii_tx #(.WIDTH(16), .DIGITS(5), .TERM_CODE(10)) u_dut_t10 (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Value(value),
    .o_Ready(rdy[2]), .o_Tx_Valid(vld[2]), .o_Tx_Byte(byt[2]), .i_Tx_Ready(tx_ready)
  );

  typedef struct {
    logic [15:0] value;
    string       digits;
    bit          toggle;
    bit          busy_pulse;
  } vec_t;

  function automatic vec_t mk(logic [15:0] v, string d, bit t, bit p);
    vec_t r;
    r.value = v;
    r.digits = d;
    r.toggle = t;
    r.busy_pulse = p;
    return r;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int unsigned qget(input int which, input int k);
    if (which == 0) return (k < q0.size()) ? {24'd0, q0[k]} : 32'h100;
    if (which == 1) return (k < q1.size()) ? {24'd0, q1[k]} : 32'h100;
    return (k < q2.size()) ? {24'd0, q2[k]} : 32'h100;
  endfunction

  task automatic run_vec(input vec_t v);
    int cyc, first_cyc, last_xfer, ready_cyc, len;
    bit stall_bad, prev_stall, finished;
    logic [7:0] prev_byte, e;
    string tag;
    q0.delete(); q1.delete(); q2.delete();
    tag = $sformatf("v%0d", v.value);
    @(posedge clk) #1;
    value = v.value; start = 1'b1; tx_ready = 1'b1;
    @(posedge clk) #1;  // start accepted at this edge (edge 0)
    start = 1'b0;
    first_cyc = -1; last_xfer = -1; ready_cyc = -1;
    stall_bad = 1'b0; prev_stall = 1'b0; prev_byte = 8'h00; finished = 1'b0;
    for (cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (prev_stall && !(vld[0] && byt[0] == prev_byte)) stall_bad = 1'b1;
      if (vld[0] && first_cyc < 0) first_cyc = cyc;
      if (vld[0] && tx_ready) begin q0.push_back(byt[0]); last_xfer = cyc; end
      if (vld[1] && tx_ready) q1.push_back(byt[1]);
      if (vld[2] && tx_ready) q2.push_back(byt[2]);
      prev_stall = vld[0] && !tx_ready;
      prev_byte = byt[0];
      if (rdy[0] && ready_cyc < 0) ready_cyc = cyc;
      if (rdy[0] && rdy[1] && rdy[2]) begin finished = 1'b1; break; end
      @(posedge clk) #1;
      if (v.toggle) tx_ready = ~tx_ready;
      if (v.busy_pulse && (cyc == 4 || cyc == first_cyc + 1)) begin
        start = 1'b1; value = 16'd9999;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    len = v.digits.len();
    check({tag, " completes"}, finished, 1);
    check({tag, " first valid latency"}, first_cyc, 17);
    check({tag, " ready after last xfer"}, ready_cyc, last_xfer + 1);
    check({tag, " byte stable in stall"}, stall_bad, 0);
    check({tag, " count term11"}, q0.size(), len + 1);
    check({tag, " count term15"}, q1.size(), len);
    check({tag, " count term10"}, q2.size(), len + 1);
    for (int k = 0; k < len; k++) begin
      e = v.digits[k];
      check($sformatf("%s byte%0d", tag, k), qget(0, k), e);
      check($sformatf("%s t15 byte%0d", tag, k), qget(1, k), e);
      check($sformatf("%s t10 byte%0d", tag, k), qget(2, k), e);
    end
    check({tag, " term ENTER"}, qget(0, len), 8'h0D);
    check({tag, " term SPACE"}, qget(2, len), 8'h20);
  endtask

  vec_t vecs [$];

  initial begin
    int cnt;
    bit hit;
    vecs.push_back(mk(16'd1234, "1234", 1'b0, 1'b0));
    vecs.push_back(mk(16'd0,    "0",    1'b0, 1'b0));
    vecs.push_back(mk(16'd7,    "7",    1'b0, 1'b0));
    vecs.push_back(mk(16'd5,    "5",    1'b1, 1'b0));
    vecs.push_back(mk(16'd1234, "1234", 1'b0, 1'b1));
    vecs.push_back(mk(16'd10000, "10000", 1'b1, 1'b0));
`ifdef DEC_TO_ASCII_SIGNED_EN
    vecs.push_back(mk(16'hFFFF, "-1",     1'b0, 1'b0));
    vecs.push_back(mk(16'h8000, "-32768", 1'b1, 1'b0));
    vecs.push_back(mk(16'h7FFF, "32767",  1'b0, 1'b0));
`else
    vecs.push_back(mk(16'd65535, "65535", 1'b1, 1'b0));
    vecs.push_back(mk(16'h8000,  "32768", 1'b0, 1'b0));
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset o_Ready", rdy[0], 1);
    check("reset o_Tx_Valid", vld[0], 0);
    check("reset o_Tx_Byte", byt[0], 8'h00);
    @(posedge clk) #1;
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while the third byte is pending: it must be dropped, not sent.
    @(posedge clk) #1;
    value = 16'd1234; start = 1'b1; tx_ready = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    cnt = 0; hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (vld[0] && cnt == 2) begin hit = 1'b1; break; end
      if (vld[0] && tx_ready) cnt++;
    end
    check("mid-reset reached 3rd byte", hit, 1);
    tx_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid-reset o_Tx_Valid", vld[0], 0);
    check("mid-reset o_Ready", rdy[0], 1);
    check("mid-reset bytes sent", cnt, 2);
    @(posedge clk) #1;
    rst = 1'b0;
    run_vec(mk(16'd42, "42", 1'b0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
